// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Shift-and-add 16-bit multiplier (low 16 bits of the product)
//               that borrows the CPU's shared combinational ALU for every add.
//               Optional macro ALU_MUL_EARLY_EXIT_EN stops once the remaining
//               multiplier is exhausted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        alu_own,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd15;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_acc;
  logic [15:0] r_mc;
  logic [15:0] r_mp;
  logic [4:0]  r_cnt;
  logic [15:0] r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
          w_next_state = (b == 16'd0) ? S_DONE : S_ADD;
`else
          w_next_state = S_ADD;
`endif
        end
      end
      S_ADD: w_next_state = S_DBL;
      S_DBL: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
        // Remaining multiplier empty after this shift: no more partial products.
        if ((r_cnt == C_LAST_ITER) || (r_mp[15:1] == 15'd0)) begin
`else
        if (r_cnt == C_LAST_ITER) begin
`endif
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ADD;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ALU drive is a pure decode of state and datapath registers.
  always_comb begin
    alu_x  = 16'd0;
    alu_y  = 16'd0;
    alu_zx = 1'b0;
    alu_nx = 1'b0;
    alu_zy = 1'b0;
    alu_ny = 1'b0;
    alu_f  = 1'b0;
    alu_no = 1'b0;
    case (r_state)
      S_ADD: begin
        alu_x = r_acc;
        alu_y = r_mc;
        alu_f = 1'b1;
      end
      S_DBL: begin
        alu_x = r_mc;
        alu_y = r_mc;
        alu_f = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= 16'd0;
      r_mc     <= 16'd0;
      r_mp     <= 16'd0;
      r_cnt    <= 5'd0;
      r_result <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= 16'd0;
            r_mc  <= a;
            r_mp  <= b;
            r_cnt <= 5'd0;
          end
        end
        S_ADD: begin
          if (r_mp[0]) begin
            r_acc <= alu_out;
          end
        end
        S_DBL: begin
          r_mc  <= alu_out;
          r_mp  <= {1'b0, r_mp[15:1]};
          r_cnt <= r_cnt + 5'd1;
        end
        S_DONE: r_result <= r_acc;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign alu_own = busy;
  assign done    = (r_state == S_DONE);
  assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Self-checking bench; models the shared ALU and scoreboards
//               products. Honours ALU_MUL_EARLY_EXIT_EN for expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        alu_own;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        done_d = 1'b0;

  alu_mul_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_own (alu_own),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out)
  );

  always #5 clk = ~clk;

  // Shared CPU ALU (zx/nx/zy/ny/f/no semantics)
  logic [15:0] w_x1, w_y1, w_o;
  always_comb begin
    w_x1 = alu_zx ? 16'd0 : alu_x;
    if (alu_nx) w_x1 = ~w_x1;
    w_y1 = alu_zy ? 16'd0 : alu_y;
    if (alu_ny) w_y1 = ~w_y1;
    w_o = alu_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    if (alu_no) w_o = ~w_o;
    alu_out = w_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // result is loaded on the closing edge of DONE, so compare one cycle later
  always @(negedge clk) begin
    if (done_d) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", result, exp_q.pop_front());
    end
    done_d = done;
  end

  function automatic int exp_lat(input logic [15:0] bb);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int hb;
    hb = -1;
    for (int j = 0; j < 16; j++) if (bb[j]) hb = j;
    return (hb < 0) ? 1 : 2 * (hb + 1) + 1;
`else
    return 33;
`endif
  endfunction

  task automatic check_alu_idle(input string tag);
    check(tag, {alu_x, alu_y}, 32'd0);
    check({tag, "_ctrl"}, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv);
    int          lat;
    int          nd;
    int          i;
    logic [15:0] mc_e;
    logic [15:0] acc_e;
    logic [31:0] bm;
    lat = exp_lat(bv);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    exp_q.push_back(16'(av * bv));
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    nd = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy", busy, 32'd1);
      check("alu_own", alu_own, 32'd1);
      check("done_timing", done, (k == lat) ? 32'd1 : 32'd0);
      if (done) nd++;
      if (k < lat) begin
        i     = (k - 1) / 2;
        mc_e  = 16'(av << i);
        bm    = {16'd0, bv} & ((32'd1 << i) - 32'd1);
        acc_e = 16'(av * bm);
        check("alu_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'b000010);
        if (k % 2 == 1) begin
          check("add_x", alu_x, acc_e);
          check("add_y", alu_y, mc_e);
        end else begin
          check("dbl_x", alu_x, mc_e);
          check("dbl_y", alu_y, mc_e);
        end
      end else begin
        check_alu_idle("done_alu");
      end
    end
    @(negedge clk);
    check("idle_busy", busy, 32'd0);
    check("idle_done", done, 32'd0);
    check("idle_own", alu_own, 32'd0);
    check_alu_idle("idle_alu");
    check("done_pulses", nd, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_own", alu_own, 32'd0);
    check("rst_result", result, 32'd0);
    check_alu_idle("rst_alu");
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(16'd3, 16'd5);
    run_op(16'hFFFF, 16'h0007);
    run_op(16'h0100, 16'h0100);
    run_op(16'h1234, 16'h0000);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'hA5C3, 16'h8001);
    for (int n = 0; n < 3; n++) run_op(16'($urandom), 16'($urandom));

    // Abort: re-start at cycle 10 is ignored, reset at cycle 12 abandons the op
    @(posedge clk); #1;
    start = 1'b1; a = 16'd9; b = 16'h8001;
    exp_q.push_back(16'(16'd9 * 16'h8001));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1; start = 1'b1; a = 16'd1; b = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_ignored_busy", busy, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 32'd0);
    check("abort_own", alu_own, 32'd0);
    check("abort_done", done, 32'd0);
    check("abort_result", result, 32'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) check("abort_no_done", done, 32'd0);
    end
    run_op(16'd7, 16'd6);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
